// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, op classification.
// Build option: ALU_DIV_EN enables the iterative unsigned divider.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_MULTU = 4'b1100,
    OP_DIVU  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  function automatic logic is_iter(alu_op_e op);
`ifdef ALU_DIV_EN
    return (op == OP_MULTU) || (op == OP_DIVU);
`else
    return (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: shift-add unsigned multiply, restoring unsigned divide.
// Build option: ALU_DIV_EN includes the divide path.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // acc:mq forms the double-width product (or remainder:quotient) register
  always_comb begin
    sum    = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    mul_hi = sum[WIDTH:1];
    mul_lo = {sum[0], mq[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             fit;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // zero divisor always "fits": quotient all ones, remainder the dividend
  always_comb begin
    shl    = {acc, mq[WIDTH-1]};
    fit    = shl >= {1'b0, opb};
    diff   = shl[WIDTH-1:0] - opb;
    div_hi = fit ? diff : shl[WIDTH-1:0];
    div_lo = {mq[WIDTH-2:0], fit};
    hi_nxt = div_q ? div_hi : mul_hi;
    lo_nxt = div_q ? div_lo : mul_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 1'b0;
    end else if (start) begin
      div_q <= is_div;
    end
  end
`else
  always_comb begin
    hi_nxt = mul_hi;
    lo_nxt = mul_lo;
  end
`endif

  assign done = step && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mq  <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      mq  <= a;
      opb <= b;
      cnt <= '0;
    end else if (step) begin
      acc <= hi_nxt;
      mq  <= lo_nxt;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: one-cycle logic/arith/shift, iterative MULTU/DIVU.
// Build option: ALU_DIV_EN enables DIVU; otherwise DIVU yields 0/0 in one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  srca,
  input  logic [WIDTH-1:0]  srcb,
  input  logic [CTRL_W-1:0] alu_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_result,
  output logic [WIDTH-1:0]  alu_result_hi,
  output logic              zero,
  output logic              busy
);

  localparam int SW = $clog2(WIDTH);

  fsm_state_e       state;
  fsm_state_e       state_nxt;
  alu_op_e          op;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_y;
  logic             start;
  logic             load;
  logic             step;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  assign op    = alu_op_e'(alu_control);
  assign shamt = srcb[SW-1:0];

  always_comb begin
    alu_y = '0;
    unique case (op)
      OP_AND:  alu_y = srca & srcb;
      OP_OR:   alu_y = srca | srcb;
      OP_ADD:  alu_y = srca + srcb;
      OP_XOR:  alu_y = srca ^ srcb;
      OP_NOR:  alu_y = ~(srca | srcb);
      OP_SLL:  alu_y = srca << shamt;
      OP_SUB:  alu_y = srca - srcb;
      OP_SLT:  alu_y = WIDTH'($signed(srca) < $signed(srcb));
      OP_SRL:  alu_y = srca >> shamt;
      OP_SRA:  alu_y = $signed(srca) >>> shamt;
      OP_SLTU: alu_y = WIDTH'(srca < srcb);
      default: alu_y = '0;
    endcase
  end

  // DONE accepts a new op in the same cycle its result is consumed
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign step      = (state == CALC);
  assign zero      = (alu_result == '0);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (in_valid && in_ready) begin
          if (is_iter(op)) begin
            start     = 1'b1;
            state_nxt = CALC;
          end else begin
            load      = 1'b1;
            state_nxt = DONE;
          end
        end else if ((state == DONE) && out_ready) begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (iter_done) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result    <= '0;
      alu_result_hi <= '0;
    end else if (load) begin
      alu_result    <= alu_y;
      alu_result_hi <= '0;
    end else if (iter_done) begin
      alu_result    <= iter_lo;
      alu_result_hi <= iter_hi;
    end
  end

  alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (reset),
    .start  (start),
    .step   (step),
`ifdef ALU_DIV_EN
    .is_div (op == OP_DIVU),
`endif
    .a      (srca),
    .b      (srcb),
    .done   (iter_done),
    .lo_nxt (iter_lo),
    .hi_nxt (iter_hi)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
// DIVU expectations follow the ALU_DIV_EN build option.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic [31:0] alu_result_hi;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int bad;

  alu_seq #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .srca          (srca),
    .srcb          (srcb),
    .alu_control   (alu_control),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .alu_result_hi (alu_result_hi),
    .zero          (zero),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present op for one cycle; lat = edges until out_valid, bounded
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int l, output int nbad);
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; srca = a; srcb = b;
    l = 0; nbad = 0;
    do begin
      @(posedge clk);
      l++;
      @(negedge clk);
      in_valid = 1'b0;
      srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
      if (!out_valid && (in_ready || !busy)) nbad++;
    end while (!out_valid && l < 100);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_ov", out_valid, 0);
  endtask

  logic [3:0]  bb_op [3];
  logic [31:0] bb_a  [3];
  logic [31:0] bb_b  [3];
  logic [31:0] bb_y  [3];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    srca = '0; srcb = '0; alu_control = '0;
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", alu_result, 0);
    chk("rst_hi", alu_result_hi, 0);
    chk("rst_zero", zero, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    do_op(OP_ADD, 32'd7, 32'd5, lat, bad);
    chk("add_lat", lat, 1);
    chk("add_res", alu_result, 12);
    chk("add_hi", alu_result_hi, 0);
    chk("add_zero", zero, 0);
    consume();

    do_op(OP_SUB, 32'd5, 32'd5, lat, bad);
    chk("sub_res", alu_result, 0);
    chk("sub_zero", zero, 1);
    consume();

    do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, bad);
    chk("slt_res", alu_result, 1);
    consume();
    do_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat, bad);
    chk("sltu_res", alu_result, 0);
    consume();
    do_op(OP_SRA, 32'h8000_0000, 32'd4, lat, bad);
    chk("sra_res", alu_result, 32'hF800_0000);
    consume();
    do_op(OP_SRL, 32'h8000_0000, 32'h24, lat, bad);
    chk("srl_res", alu_result, 32'h0800_0000);
    consume();
    do_op(OP_SLL, 32'd1, 32'd31, lat, bad);
    chk("sll_res", alu_result, 32'h8000_0000);
    consume();
    do_op(OP_NOR, 32'h0F0F_0000, 32'h0000_00F0, lat, bad);
    chk("nor_res", alu_result, 32'hF0F0_FF0F);
    consume();
    do_op(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, lat, bad);
    chk("and_res", alu_result, 32'h0F00_0F00);
    consume();
    do_op(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, lat, bad);
    chk("unsup_lat", lat, 1);
    chk("unsup_res", alu_result, 0);
    consume();

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bad);
    chk("mul_lat", lat, 33);
    chk("mul_calc", bad, 0);
    chk("mul_lo", alu_result, 32'h0000_0001);
    chk("mul_hi", alu_result_hi, 32'hFFFF_FFFE);
    consume();
    do_op(OP_MULTU, 32'h1234_5678, 32'h10, lat, bad);
    chk("mul2_lo", alu_result, 32'h2345_6780);
    chk("mul2_hi", alu_result_hi, 32'h1);
    consume();

    do_op(OP_DIVU, 32'd100, 32'd7, lat, bad);
`ifdef ALU_DIV_EN
    chk("div_lat", lat, 33);
    chk("div_q", alu_result, 14);
    chk("div_r", alu_result_hi, 2);
`else
    chk("div_lat", lat, 1);
    chk("div_q", alu_result, 0);
    chk("div_r", alu_result_hi, 0);
`endif
    consume();
    do_op(OP_DIVU, 32'd9, 32'd0, lat, bad);
`ifdef ALU_DIV_EN
    chk("div0_lat", lat, 33);
    chk("div0_q", alu_result, 32'hFFFF_FFFF);
    chk("div0_r", alu_result_hi, 9);
`else
    chk("div0_lat", lat, 1);
    chk("div0_q", alu_result, 0);
    chk("div0_r", alu_result_hi, 0);
`endif
    consume();

    do_op(OP_ADD, 32'd3, 32'd4, lat, bad);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(out_valid && !in_ready && alu_result == 32'd7)) bad++;
    end
    chk("hold_stable", bad, 0);
    out_ready = 1'b1; in_valid = 1'b1;
    alu_control = OP_OR; srca = 32'hF0; srcb = 32'h0F;
    #1;
    chk("hold_rdy", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("chain_ov", out_valid, 1);
    chk("chain_res", alu_result, 32'hFF);
    consume();

    bb_op[0] = OP_ADD; bb_a[0] = 32'd1;  bb_b[0] = 32'd2;  bb_y[0] = 32'd3;
    bb_op[1] = OP_XOR; bb_a[1] = 32'hFF; bb_b[1] = 32'h0F; bb_y[1] = 32'hF0;
    bb_op[2] = OP_SUB; bb_a[2] = 32'd0;  bb_b[2] = 32'd1;  bb_y[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("b2b_ov", out_valid, 1);
        chk("b2b_res", alu_result, bb_y[i-1]);
      end
      if (i < 3) begin
        in_valid = 1'b1; alu_control = bb_op[i];
        srca = bb_a[i]; srcb = bb_b[i];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_idle", out_valid, 0);

    in_valid = 1'b1; alu_control = OP_MULTU; srca = 32'd3; srcb = 32'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_res", alu_result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rdy", in_ready, 1);
    chk("post_ov", out_valid, 0);
    chk("post_res", alu_result, 0);
    do_op(OP_ADD, 32'd1, 32'd1, lat, bad);
    chk("post_lat", lat, 1);
    chk("post_add", alu_result, 2);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the tinymips single-cycle ALU. Implements the full MIPS integer operation set (logic, add/sub, shifts, set-less-than) with one-cycle registered latency, plus iterative unsigned multiply and divide producing a double-width result. Sits in the execute stage of the multicycle core, between the operand registers and the writeback/HI-LO registers, and stalls the control FSM through a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 8 and a power of two.
- CTRL_W, 4, width of alu_control.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block accepts an operation this cycle.
- srca  input  WIDTH  operand A / dividend / multiplicand.
- srcb  input  WIDTH  operand B / divisor / multiplier; shift amount in srcb[$clog2(WIDTH)-1:0].
- alu_control  input  CTRL_W  operation select.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- alu_result  output  WIDTH  result; product low half or quotient for MULTU/DIVU.
- alu_result_hi  output  WIDTH  product high half or remainder; 0 for all other ops.
- zero  output  1  alu_result == 0 (combinational from registered result).
- busy  output  1  iterative operation in progress.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLL, 0110 SUB, 0111 SLT (signed), 1000 SRL, 1001 SRA, 1010 SLTU, 1100 MULTU, 1101 DIVU; all others → result 0, hi 0, treated as single-cycle.
- Arithmetic modulo 2^WIDTH; no overflow flag. SLT/SLTU yield 1 or 0 zero-extended.
- FSM states IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid: single-cycle op → compute, load result regs, go DONE; MULTU/DIVU → latch operands, clear counter, go CALC.
  - CALC: busy=1, in_ready=0. One iteration per cycle (shift-add multiply; restoring divide). After WIDTH iterations load result regs, go DONE.
  - DONE: out_valid=1, result regs held stable. out_ready=1 → consumed; if in_valid also 1, accept new op in the same cycle (in_ready = out_ready) and branch as from IDLE; otherwise go IDLE.
- DIVU by zero: alu_result = all ones, alu_result_hi = srca; still takes full WIDTH iterations.
- Inputs ignored whenever in_ready=0; operands are latched at acceptance, so they may change afterwards.

## Timing
- Reset (asynchronous, any state including mid-CALC): state IDLE, counter 0, out_valid 0, busy 0, alu_result 0, alu_result_hi 0, hence zero=1; in_ready=1 in the first cycle after deassertion.
- Single-cycle op accepted at edge N → out_valid=1 after edge N+1.
- MULTU/DIVU accepted at edge N → out_valid=1 after edge N+WIDTH+1 (WIDTH CALC cycles).
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- out_valid stays high and results stable until out_ready is sampled high.
- Iteration counter width $clog2(WIDTH)+1; terminal count WIDTH-1.

## Configuration
- ALU_DIV_EN defined: DIVU implemented as above.
- ALU_DIV_EN undefined: divider datapath absent; DIVU decodes as unsupported (result 0, hi 0, one-cycle latency). MULTU unaffected.

## Structure
- Package alu_seq_pkg: alu_op_e opcode enum (CTRL_W bits), fsm_state_e enum, opcode-is-iterative helper function.
- Sub-module alu_seq_iter: iterative multiply/divide engine (operand/accumulator regs, counter, start/done), instantiated once; divide path inside guarded by ALU_DIV_EN. Single-cycle datapath and FSM stay in alu_seq.

## Test plan
- Reset then ADD srca=7, srcb=5 → alu_result=12, zero=0, out_valid one cycle after acceptance; SUB 5-5 → 0, zero=1.
- SLT srca=0xFFFFFFFF, srcb=1 → 1; SLTU same operands → 0; SRA 0x80000000 by 4 → 0xF8000000.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) → hi 0xFFFFFFFE, lo 0x00000001, out_valid exactly 33 cycles after acceptance, in_ready=0 and busy=1 throughout CALC.
- DIVU 100 / 7 → quotient 14, remainder 2; DIVU 9 / 0 → 0xFFFFFFFF, remainder 9; without ALU_DIV_EN → 0/0 after one cycle.
- out_ready held low 5 cycles in DONE → result stable, in_ready=0; then out_ready=1 with in_valid=1 (OR 0xF0|0x0F) → new op accepted same cycle, next result 0xFF.
- Reset asserted mid-MULTU → next cycle IDLE, out_valid=0, alu_result=0; subsequent ADD 1+1 → 2.
